// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants and types for the PS/2 scan-code controller.
package ps2_kbd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGotE0   = 2'd1,
    StGotF0   = 2'd2,
    StGotE0F0 = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PfxExt = 8'hE0;
  localparam logic [7:0] PfxBrk = 8'hF0;
  localparam logic [7:0] BatOk  = 8'hAA;
  localparam logic [7:0] Ack    = 8'hFA;
  localparam logic [7:0] Resend = 8'hFE;
  localparam logic [7:0] Err0   = 8'h00;
  localparam logic [7:0] Err1   = 8'hFF;

  // Event layout: {ext, brk, code}.
  localparam int unsigned EvW = 10;

  function automatic logic [EvW-1:0] pack_ev(logic [7:0] code, logic ext, logic brk);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event valid/ready channel between the controller and its consumer.
interface ps2_kbd_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;

    modport master (output ev_valid, output ev_code, output ev_ext, output ev_brk,
                    input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_ext, input ev_brk,
                    output ev_ready);
endinterface

// File: rtl/ps2_ev_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on rdata while not empty.
module ps2_ev_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q;
    logic             do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(Depth));
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push  = push & (~full | do_pop);
    assign rdata    = mem_q[rd_ptr_q];
    assign overflow = ovf_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            if (push & full & ~do_pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code controller: parses E0/F0 prefixes into key events and queues them.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 250000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx_done_tick,
    input  logic [7:0]           rx_data,
    output logic                 rx_en,
    output logic                 err_tick,
    output logic                 overflow,
    ps2_kbd_ctrl_if.master       ev
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    ps2_state_e     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           timeout;
    logic           push;
    logic [EvW-1:0] push_ev;
    logic [EvW-1:0] head_ev, out_ev;
    logic           err_d, err_q;
    logic           rx_en_q;
    logic           fifo_full, fifo_empty;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = (state_q != StIdle) && !rx_done_tick &&
                     (timer_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rx_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == PfxExt)      state_d = StGotE0;
                    else if (rx_data == PfxBrk) state_d = StGotF0;
                end
                StGotE0: begin
                    if (rx_data == PfxBrk)      state_d = StGotE0F0;
                    else if (rx_data != PfxExt) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        push    = 1'b0;
        err_d   = 1'b0;
        push_ev = pack_ev(rx_data, 1'b0, 1'b0);
        if (rx_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    unique case (rx_data)
                        PfxExt, PfxBrk, BatOk, Ack, Resend: ;
                        Err0, Err1: err_d = 1'b1;
                        default:    push  = 1'b1;
                    endcase
                end
                StGotE0: begin
                    push    = (rx_data != PfxExt) && (rx_data != PfxBrk);
                    push_ev = pack_ev(rx_data, 1'b1, 1'b0);
                end
                StGotF0: begin
                    push    = (rx_data != PfxExt) && (rx_data != PfxBrk);
                    err_d   = !push;
                    push_ev = pack_ev(rx_data, 1'b0, 1'b1);
                end
                default: begin
                    push    = (rx_data != PfxExt) && (rx_data != PfxBrk);
                    err_d   = !push;
                    push_ev = pack_ev(rx_data, 1'b1, 1'b1);
                end
            endcase
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (rx_done_tick || (state_q == StIdle) || timeout) timer_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
            rx_en_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
            rx_en_q <= enable & ~fifo_full;
        end
    end

    ps2_ev_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EvW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (ev.ev_ready),
        .wdata    (push_ev),
        .rdata    (head_ev),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    // Head is forced to zero while empty so idle outputs match reset values.
    assign out_ev      = fifo_empty ? '0 : head_ev;
    assign ev.ev_valid = ~fifo_empty;
    assign ev.ev_ext   = out_ev[9];
    assign ev.ev_brk   = out_ev[8];
    assign ev.ev_code  = out_ev[7:0];
    assign rx_en       = rx_en_q;
    assign err_tick    = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with hand-computed expected events.
module tb_ps2_kbd_ctrl;
    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en, err_tick, overflow;
    int         nvec = 0;
    int         nerr = 0;

    ps2_kbd_ctrl_if ev_if ();

    ps2_kbd_ctrl #(
        .FIFO_DEPTH  (Depth),
        .TIMEOUT_CYC (Tmo)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .err_tick     (err_tick),
        .overflow     (overflow),
        .ev           (ev_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        rx_data      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] code, input logic ext,
                              input logic brk);
        chk({tag, ".valid"}, 16'(ev_if.ev_valid), 16'd1);
        chk({tag, ".code"}, 16'(ev_if.ev_code), 16'(code));
        chk({tag, ".ext"}, 16'(ev_if.ev_ext), 16'(ext));
        chk({tag, ".brk"}, 16'(ev_if.ev_brk), 16'(brk));
        ev_if.ev_ready = 1'b1;
        tick();
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        #1;
        tick();
        chk("rst.rx_en", 16'(rx_en), 16'd0);
        chk("rst.valid", 16'(ev_if.ev_valid), 16'd0);
        chk("rst.code", 16'(ev_if.ev_code), 16'd0);
        chk("rst.ext", 16'(ev_if.ev_ext), 16'd0);
        chk("rst.brk", 16'(ev_if.ev_brk), 16'd0);
        chk("rst.err", 16'(err_tick), 16'd0);
        chk("rst.ovf", 16'(overflow), 16'd0);
        reset = 1'b0;
        tick();
        chk("rx_en.up", 16'(rx_en), 16'd1);

        // Make / extended make / extended break / break
        send(8'h1C);
        expect_pop("ev1", 8'h1C, 1'b0, 1'b0);
        chk("ev1.empty", 16'(ev_if.ev_valid), 16'd0);
        send(8'hE0);
        chk("e0.noev", 16'(ev_if.ev_valid), 16'd0);
        send(8'h75);
        expect_pop("ev2", 8'h75, 1'b1, 1'b0);
        send(8'hE0);
        send(8'hF0);
        chk("e0f0.noev", 16'(ev_if.ev_valid), 16'd0);
        send(8'h75);
        expect_pop("ev3", 8'h75, 1'b1, 1'b1);
        send(8'hF0);
        send(8'h1C);
        expect_pop("ev4", 8'h1C, 1'b0, 1'b1);

        // Fill and overflow
        send(8'h15);
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        chk("full.rx_en_lag", 16'(rx_en), 16'd1);
        tick();
        chk("full.rx_en", 16'(rx_en), 16'd0);
        chk("full.ovf0", 16'(overflow), 16'd0);
        send(8'h25);
        chk("ovf.set", 16'(overflow), 16'd1);
        send(8'h2E);
        chk("ovf.head_stable", 16'(ev_if.ev_code), 16'h15);
        expect_pop("dr1", 8'h15, 1'b0, 1'b0);
        expect_pop("dr2", 8'h16, 1'b0, 1'b0);
        expect_pop("dr3", 8'h1E, 1'b0, 1'b0);
        expect_pop("dr4", 8'h26, 1'b0, 1'b0);
        chk("dr.empty", 16'(ev_if.ev_valid), 16'd0);
        chk("ovf.sticky", 16'(overflow), 16'd1);
        chk("dr.rx_en", 16'(rx_en), 16'd1);

        // Timeout after a lone E0
        do_reset();
        send(8'hE0);
        repeat (Tmo - 1) tick();
        chk("tmo.pre", 16'(err_tick), 16'd0);
        tick();
        chk("tmo.pulse", 16'(err_tick), 16'd1);
        tick();
        chk("tmo.post", 16'(err_tick), 16'd0);
        chk("tmo.noev", 16'(ev_if.ev_valid), 16'd0);
        send(8'h1C);
        expect_pop("tmo.ev", 8'h1C, 1'b0, 1'b0);

        // Silent discards and error byte
        send(8'hAA);
        chk("aa.err", 16'(err_tick), 16'd0);
        send(8'hFA);
        chk("fa.err", 16'(err_tick), 16'd0);
        send(8'h00);
        chk("00.err", 16'(err_tick), 16'd1);
        tick();
        chk("00.err_off", 16'(err_tick), 16'd0);
        chk("disc.noev", 16'(ev_if.ev_valid), 16'd0);

        // Simultaneous push and pop at full
        send(8'h11);
        send(8'h12);
        send(8'h13);
        send(8'h14);
        tick();
        rx_data        = 8'h29;
        rx_done_tick   = 1'b1;
        ev_if.ev_ready = 1'b1;
        tick();
        rx_done_tick   = 1'b0;
        ev_if.ev_ready = 1'b0;
        chk("pp.ovf", 16'(overflow), 16'd0);
        expect_pop("pp1", 8'h12, 1'b0, 1'b0);
        expect_pop("pp2", 8'h13, 1'b0, 1'b0);
        expect_pop("pp3", 8'h14, 1'b0, 1'b0);
        expect_pop("pp4", 8'h29, 1'b0, 1'b0);
        chk("pp.empty", 16'(ev_if.ev_valid), 16'd0);

        // enable=0 drops rx_en
        enable = 1'b0;
        tick();
        tick();
        chk("en0.rx_en", 16'(rx_en), 16'd0);
        enable = 1'b1;

        // Reset between F0 and 1C
        send(8'hF0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.rx_en", 16'(rx_en), 16'd0);
        chk("midrst.valid", 16'(ev_if.ev_valid), 16'd0);
        tick();
        reset = 1'b0;
        tick();
        send(8'h1C);
        expect_pop("midrst.ev", 8'h1C, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
